exe_redirect_ctrl: RTL and testbench

Sequencing controller for the execution stage's branch/jump resolution outputs. It turns a resolved taken branch, JAL or JALR, or an instruction-address-misaligned fault, into a redirect handshake toward fetch, a multi-cycle squash of younger pipeline stages, and a one-cycle trap pulse toward the CSR unit. It sits between the execution stage and the fetch/decode pipeline registers, and is the only source of control-flow redirects.

---
 rtl/exe_redirect_ctrl_if.sv | 43 ++++
 rtl/exe_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_exe_redirect_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_redirect_ctrl_if.sv
// Redirect/trap bundle between execute, the redirect controller and fetch; stats ports exist only with REDIRECT_STATS_EN.
// Latency: wiring only, no state.
// Backpressure: fetch_ready_i is the only backpressure signal; the controller holds the redirect until it is seen high.
interface exe_redirect_ctrl_if;
    logic        exe_valid_i;
    logic        is_br_inst_i;
    logic        is_jump_i;
    logic        br_cond_i;
    logic        is_br_j_taken_i;
    logic        e_inst_addr_mis_i;
    logic [31:0] br_j_addr_i;
    logic [31:0] pc_i;
    logic [31:0] mtvec_i;
    logic        fetch_ready_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_addr_o;
    logic        flush_o;
    logic        trap_o;
    logic [31:0] trap_epc_o;
    logic        busy_o;
`ifdef REDIRECT_STATS_EN
    logic [31:0] redirect_cnt_o;
    logic [31:0] trap_cnt_o;
`endif

    modport master (
        output exe_valid_i, is_br_inst_i, is_jump_i, br_cond_i, is_br_j_taken_i,
               e_inst_addr_mis_i, br_j_addr_i, pc_i, mtvec_i, fetch_ready_i,
`ifdef REDIRECT_STATS_EN
        input  redirect_cnt_o, trap_cnt_o,
`endif
        input  redirect_valid_o, redirect_addr_o, flush_o, trap_o, trap_epc_o, busy_o
    );

    modport slave (
        input  exe_valid_i, is_br_inst_i, is_jump_i, br_cond_i, is_br_j_taken_i,
               e_inst_addr_mis_i, br_j_addr_i, pc_i, mtvec_i, fetch_ready_i,
`ifdef REDIRECT_STATS_EN
        output redirect_cnt_o, trap_cnt_o,
`endif
        output redirect_valid_o, redirect_addr_o, flush_o, trap_o, trap_epc_o, busy_o
    );
endinterface

// File: rtl/exe_redirect_ctrl.sv
// Execute-stage redirect sequencer: taken branch/jump or misaligned-target trap -> fetch redirect, IF/ID squash, trap pulse.
// Latency: event sampled at edge N drives redirect/flush/busy in cycle N+1; busy for 1+FLUSH_CYCLES cycles best case.
// Backpressure: redirect held stable until fetch_ready_i; new events ignored while busy. REDIRECT_STATS_EN adds counters.
module exe_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    exe_redirect_ctrl_if.slave  bus
);
    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   target_q, target_d;
    logic [31:0]   epc_q, epc_d;
    logic          trap_flag_q, trap_flag_d;
    logic          first_q, first_d;
    logic          trap_ev, redir_ev, accept;

    // A misaligned not-taken branch raises neither event: br_cond_i gates the trap term.
    assign trap_ev  = bus.exe_valid_i & bus.e_inst_addr_mis_i &
                      (bus.is_jump_i | (bus.is_br_inst_i & bus.br_cond_i));
    assign redir_ev = bus.exe_valid_i & bus.is_br_j_taken_i;
    assign accept   = (state_q == REDIRECT) & bus.fetch_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            target_q    <= '0;
            epc_q       <= '0;
            trap_flag_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            epc_q       <= epc_d;
            trap_flag_q <= trap_flag_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        epc_d       = epc_q;
        trap_flag_d = trap_flag_q;
        first_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap_ev) begin
                    target_d    = {bus.mtvec_i[31:2], 2'b00};
                    epc_d       = bus.pc_i;
                    trap_flag_d = 1'b1;
                    first_d     = 1'b1;
                    state_d     = REDIRECT;
                end else if (redir_ev) begin
                    target_d    = bus.br_j_addr_i;
                    trap_flag_d = 1'b0;
                    first_d     = 1'b1;
                    state_d     = REDIRECT;
                end
            end
            REDIRECT: begin
                if (bus.fetch_ready_i) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // first_q is high only in the entry cycle of REDIRECT, so a stalled trap still pulses once.
    assign bus.redirect_valid_o = (state_q == REDIRECT);
    assign bus.flush_o          = (state_q != IDLE);
    assign bus.busy_o           = (state_q != IDLE);
    assign bus.trap_o           = (state_q == REDIRECT) & first_q & trap_flag_q;
    assign bus.redirect_addr_o  = target_q;
    assign bus.trap_epc_o       = epc_q;

`ifdef REDIRECT_STATS_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] trap_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_cnt_q <= '0;
            trap_cnt_q     <= '0;
        end else if (accept) begin
            if (trap_flag_q) begin
                trap_cnt_q <= trap_cnt_q + 32'd1;
            end else begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign bus.redirect_cnt_o = redirect_cnt_q;
    assign bus.trap_cnt_o     = trap_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_exe_redirect_ctrl.sv
// Directed bench for exe_redirect_ctrl (FLUSH_CYCLES=2 instance plus a FLUSH_CYCLES=0 instance).
module tb_exe_redirect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exe_redirect_ctrl_if bus ();
    exe_redirect_ctrl_if bus0 ();

    exe_redirect_ctrl #(.FLUSH_CYCLES(2)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    exe_redirect_ctrl #(.FLUSH_CYCLES(0)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));

    task automatic drive(input logic v, br, jmp, cond, tkn, mis,
                         input logic [31:0] tgt, pc, mtv, input logic rdy);
        bus.exe_valid_i       = v;
        bus.is_br_inst_i      = br;
        bus.is_jump_i         = jmp;
        bus.br_cond_i         = cond;
        bus.is_br_j_taken_i   = tkn;
        bus.e_inst_addr_mis_i = mis;
        bus.br_j_addr_i       = tgt;
        bus.pc_i              = pc;
        bus.mtvec_i           = mtv;
        bus.fetch_ready_i     = rdy;
    endtask

    task automatic drive0(input logic v, tkn, jmp, mis, input logic [31:0] tgt, input logic rdy);
        bus0.exe_valid_i       = v;
        bus0.is_br_inst_i      = 1'b0;
        bus0.is_jump_i         = jmp;
        bus0.br_cond_i         = 1'b0;
        bus0.is_br_j_taken_i   = tkn;
        bus0.e_inst_addr_mis_i = mis;
        bus0.br_j_addr_i       = tgt;
        bus0.pc_i              = 32'h0000_0400;
        bus0.mtvec_i           = 32'h0000_0800;
        bus0.fetch_ready_i     = rdy;
    endtask

    function automatic logic [3:0] st();
        return {bus.redirect_valid_o, bus.flush_o, bus.trap_o, bus.busy_o};
    endfunction

    function automatic logic [3:0] st0();
        return {bus0.redirect_valid_o, bus0.flush_o, bus0.trap_o, bus0.busy_o};
    endfunction

    // status nibble = {redirect_valid, flush, trap, busy}
    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        drive0(0, 0, 0, 0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (st() !== 4'b0000) begin failures++; $display("FAIL reset_status got=%b exp=0000", st()); end
        checks++; if (bus.redirect_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.redirect_addr_o); end
        checks++; if (bus.trap_epc_o !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", bus.trap_epc_o); end
        checks++; if (st0() !== 4'b0000) begin failures++; $display("FAIL reset_status0 got=%b exp=0000", st0()); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_taken_beq();
        logic [3:0] e [0:3];
        e = '{4'b1101, 4'b0101, 4'b0101, 4'b0000};
        drive(1, 1, 0, 1, 1, 0, 32'h0000_0040, 32'h0000_0010, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.exe_valid_i = 1'b0;
            checks++; if (st() !== e[i]) begin failures++; $display("FAIL beq_status c%0d got=%b exp=%b", i + 1, st(), e[i]); end
            checks++; if (bus.redirect_addr_o !== 32'h40) begin failures++; $display("FAIL beq_addr c%0d got=%h exp=40", i + 1, bus.redirect_addr_o); end
        end
    endtask

    task automatic test_trap_jalr();
        logic [3:0] e [0:3];
        e = '{4'b1111, 4'b0101, 4'b0101, 4'b0000};
        drive(1, 0, 1, 0, 0, 1, 32'h0000_0102, 32'h0000_0200, 32'h0000_0103, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.exe_valid_i = 1'b0;
            checks++; if (st() !== e[i]) begin failures++; $display("FAIL jalr_status c%0d got=%b exp=%b", i + 1, st(), e[i]); end
            checks++; if (bus.redirect_addr_o !== 32'h100) begin failures++; $display("FAIL jalr_addr c%0d got=%h exp=100", i + 1, bus.redirect_addr_o); end
            checks++; if (bus.trap_epc_o !== 32'h200) begin failures++; $display("FAIL jalr_epc c%0d got=%h exp=200", i + 1, bus.trap_epc_o); end
        end
    endtask

    task automatic test_trap_priority();
        drive(1, 1, 0, 1, 1, 1, 32'h0000_0044, 32'h0000_02c0, 32'h0000_2002, 1'b1);
        @(negedge clk);
        bus.exe_valid_i = 1'b0;
        checks++; if (st() !== 4'b1111) begin failures++; $display("FAIL prio_status got=%b exp=1111", st()); end
        checks++; if (bus.redirect_addr_o !== 32'h2000) begin failures++; $display("FAIL prio_addr got=%h exp=2000", bus.redirect_addr_o); end
        checks++; if (bus.trap_epc_o !== 32'h2c0) begin failures++; $display("FAIL prio_epc got=%h exp=2c0", bus.trap_epc_o); end
        repeat (3) @(negedge clk);
        checks++; if (st() !== 4'b0000) begin failures++; $display("FAIL prio_idle got=%b exp=0000", st()); end
    endtask

    task automatic test_mis_not_taken();
        drive(1, 1, 0, 0, 0, 1, 32'h0000_0302, 32'h0000_0600, 32'h0000_4000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) bus.exe_valid_i = 1'b0;
            checks++; if (st() !== 4'b0000) begin failures++; $display("FAIL misnt_status c%0d got=%b exp=0000", i + 1, st()); end
        end
        checks++; if (bus.redirect_addr_o !== 32'h2000) begin failures++; $display("FAIL misnt_addr_hold got=%h exp=2000", bus.redirect_addr_o); end
        checks++; if (bus.trap_epc_o !== 32'h2c0) begin failures++; $display("FAIL misnt_epc_hold got=%h exp=2c0", bus.trap_epc_o); end
    endtask

    task automatic test_stall();
        logic [3:0] e [0:6];
        e = '{4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b0101, 4'b0101, 4'b0000};
        drive(1, 0, 1, 0, 0, 1, 32'h0000_0a0a, 32'h0000_0300, 32'h0000_1001, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++; if (st() !== e[i]) begin failures++; $display("FAIL stall_status c%0d got=%b exp=%b", i + 1, st(), e[i]); end
            checks++; if (bus.redirect_addr_o !== 32'h1000) begin failures++; $display("FAIL stall_addr c%0d got=%h exp=1000", i + 1, bus.redirect_addr_o); end
            checks++; if (bus.trap_epc_o !== 32'h300) begin failures++; $display("FAIL stall_epc c%0d got=%h exp=300", i + 1, bus.trap_epc_o); end
            if (i == 0) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);
            if (i == 1) drive(1, 1, 0, 1, 1, 0, 32'h0000_0500, 32'h0000_0700, 32'h0, 1'b0);
            if (i == 2) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);
            if (i == 3) bus.fetch_ready_i = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  e [0:7];
        logic [31:0] a [0:7];
        e = '{4'b1101, 4'b0101, 4'b0101, 4'b0000, 4'b1101, 4'b0101, 4'b0101, 4'b0000};
        a = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h60, 32'h60, 32'h60, 32'h60};
        drive(1, 0, 1, 0, 1, 0, 32'h0000_0044, 32'h0000_0020, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (st() !== e[i]) begin failures++; $display("FAIL b2b_status c%0d got=%b exp=%b", i + 1, st(), e[i]); end
            checks++; if (bus.redirect_addr_o !== a[i]) begin failures++; $display("FAIL b2b_addr c%0d got=%h exp=%h", i + 1, bus.redirect_addr_o, a[i]); end
            if (i == 0) bus.br_j_addr_i = 32'h0000_0060;
            if (i == 4) bus.exe_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 1, 1, 0, 32'h0000_0088, 32'h0000_0030, 32'h0, 1'b1);
        @(negedge clk);
        bus.exe_valid_i = 1'b0;
        checks++; if (st() !== 4'b1101) begin failures++; $display("FAIL rstmid_c1 got=%b exp=1101", st()); end
        @(negedge clk);
        checks++; if (st() !== 4'b0101) begin failures++; $display("FAIL rstmid_c2 got=%b exp=0101", st()); end
        @(negedge clk);
        checks++; if (st() !== 4'b0101) begin failures++; $display("FAIL rstmid_c3 got=%b exp=0101", st()); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (st() !== 4'b0000) begin failures++; $display("FAIL rstmid_status got=%b exp=0000", st()); end
        checks++; if (bus.redirect_addr_o !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", bus.redirect_addr_o); end
        // stalled redirect dropped by reset
        drive(1, 0, 1, 0, 0, 1, 32'h0, 32'h0000_0050, 32'h0000_0c00, 1'b0);
        @(negedge clk);
        bus.exe_valid_i = 1'b0;
        checks++; if (st() !== 4'b1111) begin failures++; $display("FAIL rstredir_c1 got=%b exp=1111", st()); end
        @(negedge clk);
        checks++; if (st() !== 4'b1101) begin failures++; $display("FAIL rstredir_c2 got=%b exp=1101", st()); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (st() !== 4'b0000) begin failures++; $display("FAIL rstredir_status got=%b exp=0000", st()); end
        checks++; if (bus.trap_epc_o !== 32'h0) begin failures++; $display("FAIL rstredir_epc got=%h exp=0", bus.trap_epc_o); end
        @(negedge clk);
        checks++; if (st() !== 4'b0000) begin failures++; $display("FAIL rstredir_after got=%b exp=0000", st()); end
        drive(1, 1, 0, 1, 1, 0, 32'h0000_0090, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        bus.exe_valid_i = 1'b0;
        checks++; if (st() !== 4'b1101 || bus.redirect_addr_o !== 32'h90) begin failures++; $display("FAIL rstmid_fresh got=%b/%h exp=1101/90", st(), bus.redirect_addr_o); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flush0();
        drive0(1, 1, 0, 0, 32'h0000_0010, 1'b1);
        @(negedge clk);
        bus0.exe_valid_i = 1'b0;
        checks++; if (st0() !== 4'b1101) begin failures++; $display("FAIL f0_c1 got=%b exp=1101", st0()); end
        checks++; if (bus0.redirect_addr_o !== 32'h10) begin failures++; $display("FAIL f0_addr got=%h exp=10", bus0.redirect_addr_o); end
        @(negedge clk);
        checks++; if (st0() !== 4'b0000) begin failures++; $display("FAIL f0_c2 got=%b exp=0000", st0()); end
        drive0(1, 0, 1, 1, 32'h0000_0013, 1'b1);
        @(negedge clk);
        bus0.exe_valid_i = 1'b0;
        checks++; if (st0() !== 4'b1111 || bus0.redirect_addr_o !== 32'h800) begin failures++; $display("FAIL f0_trap got=%b/%h exp=1111/800", st0(), bus0.redirect_addr_o); end
        @(negedge clk);
        checks++; if (st0() !== 4'b0000) begin failures++; $display("FAIL f0_trap_idle got=%b exp=0000", st0()); end
    endtask

`ifdef REDIRECT_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.redirect_cnt_o !== 32'd0 || bus.trap_cnt_o !== 32'd0) begin failures++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", bus.redirect_cnt_o, bus.trap_cnt_o); end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) drive(1, 0, 1, 0, 0, 1, 32'h0, 32'h0000_0100, 32'h0000_0200, 1'b1);
            else        drive(1, 1, 0, 1, 1, 0, 32'h0000_0040, 32'h0, 32'h0, 1'b1);
            @(negedge clk);
            bus.exe_valid_i = 1'b0;
            repeat (3) @(negedge clk);
        end
        checks++; if (bus.redirect_cnt_o !== 32'd3) begin failures++; $display("FAIL stats_redirect got=%0d exp=3", bus.redirect_cnt_o); end
        checks++; if (bus.trap_cnt_o !== 32'd1) begin failures++; $display("FAIL stats_trap got=%0d exp=1", bus.trap_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_taken_beq();
        test_trap_jalr();
        test_trap_priority();
        test_mis_not_taken();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_flush0();
`ifdef REDIRECT_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
